fetch_unit: RTL and testbench

//  Instruction-fetch stage feeding the 5-stage pipeline's ID stage: owns the PC, issues
//  req/ack fetches to instruction memory, and drives the IF/ID register (inst, PC+4, valid).

---
 rtl/cpu_pkg.sv | 14 +
 rtl/inst_hold_buf.sv | 36 +++
 rtl/fetch_unit.sv | 146 ++++++++++++++
 tb/tb_fetch_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants.
// Used by the fetch stage and its hold buffer.
package cpu_pkg;

  localparam logic [31:0] NOP_INST     = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/inst_hold_buf.sv
// One-entry {inst, pc4} buffer that parks a fetch
// response arriving while ID is stalled.
module inst_hold_buf
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [INST_W-1:0] d_inst,
  input  logic [ADDR_W-1:0] d_pc4,
  output logic              valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] pc4
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      inst  <= INST_W'(NOP_INST);
      pc4   <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      inst  <= INST_W'(NOP_INST);
      pc4   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      inst  <= d_inst;
      pc4   <= d_pc4;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem req/ack fetch,
// IF/ID register, stall hold and branch redirect.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  output logic              if_id_valid_o,
  output logic [INST_W-1:0] if_id_inst_o,
  output logic [ADDR_W-1:0] if_id_pc4_o
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              drop_q, drop_d;
  logic              v_q, v_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;
  logic [ADDR_W-1:0] pc_plus4;
  logic              ack;
  logic              buf_load, buf_clear, buf_valid;
  logic [INST_W-1:0] buf_inst;
  logic [ADDR_W-1:0] buf_pc4;

  assign imem_req_o    = (state_q == FETCH);
  assign imem_addr_o   = pc_q;
  assign ack           = imem_req_o & imem_ack_i;
  assign pc_plus4      = pc_q + ADDR_W'(4);
  assign if_id_valid_o = v_q;
  assign if_id_inst_o  = inst_q;
  assign if_id_pc4_o   = pc4_q;

  inst_hold_buf #(
    .ADDR_W(ADDR_W),
    .INST_W(INST_W)
  ) u_buf (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .load  (buf_load),
    .clear (buf_clear),
    .d_inst(imem_rdata_i),
    .d_pc4 (pc_plus4),
    .valid (buf_valid),
    .inst  (buf_inst),
    .pc4   (buf_pc4)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    drop_d    = drop_q;
    v_d       = v_q;
    inst_d    = inst_q;
    pc4_d     = pc4_q;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    // bubble unless something real arrives below
    if (!stall_i || flush_i) begin
      v_d    = 1'b0;
      inst_d = INST_W'(NOP_INST);
      pc4_d  = '0;
    end
    unique case (state_q)
      IDLE: begin
        if (flush_i) pc_d = branch_target_i;
        if (start_i) state_d = FETCH;
      end
      FETCH: begin
        if (flush_i) begin
          buf_clear = 1'b1;
          if (ack) begin
            pc_d   = branch_target_i;
            drop_d = 1'b0;
          end else begin
            drop_d = 1'b1;
            tgt_d  = branch_target_i;
          end
        end else if (ack) begin
          if (drop_q) begin
            pc_d   = tgt_q;
            drop_d = 1'b0;
          end else begin
            pc_d = pc_plus4;
            if (!stall_i) begin
              v_d    = 1'b1;
              inst_d = imem_rdata_i;
              pc4_d  = pc_plus4;
            end else begin
              buf_load = 1'b1;
              state_d  = FULL;
            end
          end
        end
      end
      FULL: begin
        if (flush_i) begin
          state_d   = FETCH;
          pc_d      = branch_target_i;
          buf_clear = 1'b1;
        end else if (!stall_i) begin
          v_d       = buf_valid;
          inst_d    = buf_inst;
          pc4_d     = buf_pc4;
          buf_clear = 1'b1;
          state_d   = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      drop_q  <= 1'b0;
      v_q     <= 1'b0;
      inst_q  <= INST_W'(NOP_INST);
      pc4_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      drop_q  <= drop_d;
      v_q     <= v_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: imem responder with ack
// gating, scoreboard of expected IF/ID entries.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] target = 32'h0;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;
  logic        valid;
  logic [31:0] inst;
  logic [31:0] pc4;
  logic        ack_en = 1'b0;
  logic        stall_seen = 1'b0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc4;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  assign ack   = req & ack_en;
  assign rdata = addr | 32'hA000_0000;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .start_i        (start),
    .stall_i        (stall),
    .flush_i        (flush),
    .branch_target_i(target),
    .imem_req_o     (req),
    .imem_addr_o    (addr),
    .imem_ack_i     (ack),
    .imem_rdata_i   (rdata),
    .if_id_valid_o  (valid),
    .if_id_inst_o   (inst),
    .if_id_pc4_o    (pc4)
  );

  always @(posedge clk) stall_seen <= stall;

  // IF/ID reloads on every unstalled edge; pop one entry per real instruction
  always @(negedge clk) begin
    if (rst_n && valid && !stall_seen) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got inst=%h pc4=%h, none expected",
                 inst, pc4);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (inst !== e.inst || pc4 !== e.pc4) begin
          n_fail++;
          $display("FAIL sb_ifid: got inst=%h pc4=%h want inst=%h pc4=%h",
                   inst, pc4, e.inst, e.pc4);
        end
      end
    end
  end

  function automatic void push(input logic [31:0] a);
    exp_t e;
    e.inst = a | 32'hA000_0000;
    e.pc4  = a + 32'd4;
    q.push_back(e);
  endfunction

  task automatic test_reset;
    @(negedge clk);
    n_checks++;
    if (req !== 1'b0 || addr !== 32'h0 || valid !== 1'b0 ||
        inst !== 32'h0 || pc4 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: req=%b addr=%h v=%b inst=%h pc4=%h want 0s",
               req, addr, valid, inst, pc4);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle: req=%b v=%b want 0 0", req, valid);
    end
    start  = 1'b1;
    ack_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero_wait;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (req !== 1'b1 || addr !== 32'(4 * i)) begin
        n_fail++;
        $display("FAIL zw_addr%0d: req=%b addr=%h want 1 %h",
                 i, req, addr, 32'(4 * i));
      end
      push(32'(4 * i));
      @(negedge clk);
    end
  endtask

  task automatic test_wait_ack;
    n_checks++;
    if (req !== 1'b1 || addr !== 32'h8) begin
      n_fail++;
      $display("FAIL wait_first: req=%b addr=%h want 1 00000008", req, addr);
    end
    ack_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (req !== 1'b1 || addr !== 32'h8 || valid !== 1'b0 ||
          inst !== 32'h0) begin
        n_fail++;
        $display("FAIL wait_hold%0d: req=%b addr=%h v=%b inst=%h want 1 8 0 0",
                 i, req, addr, valid, inst);
      end
    end
    ack_en = 1'b1;
    push(32'h8);
    @(negedge clk);
    n_checks++;
    if (addr !== 32'hC) begin
      n_fail++;
      $display("FAIL wait_next: addr=%h want 0000000c", addr);
    end
    push(32'hC);
    @(negedge clk);
  endtask

  task automatic test_stall;
    n_checks++;
    if (req !== 1'b1 || addr !== 32'h10) begin
      n_fail++;
      $display("FAIL stall_pre: req=%b addr=%h want 1 00000010", req, addr);
    end
    stall = 1'b1;
    push(32'h10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ack_en = 1'b0;
      n_checks++;
      if (req !== 1'b0 || valid !== 1'b1 || inst !== 32'hA000_000C ||
          pc4 !== 32'h10) begin
        n_fail++;
        $display("FAIL stall_frozen%0d: req=%b v=%b inst=%h pc4=%h want 0 1 a000000c 10",
                 i, req, valid, inst, pc4);
      end
    end
    stall = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req !== 1'b1 || addr !== 32'h14) begin
      n_fail++;
      $display("FAIL stall_resume: req=%b addr=%h want 1 00000014", req, addr);
    end
  endtask

  task automatic test_flush_outstanding;
    flush  = 1'b1;
    target = 32'h40;
    ack_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      flush = 1'b0;
      n_checks++;
      if (req !== 1'b1 || addr !== 32'h14 || valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_hold%0d: req=%b addr=%h v=%b want 1 14 0",
                 i, req, addr, valid);
      end
    end
    ack_en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req !== 1'b1 || addr !== 32'h40 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_redirect: req=%b addr=%h v=%b want 1 40 0",
               req, addr, valid);
    end
    push(32'h40);
    @(negedge clk);
    n_checks++;
    if (addr !== 32'h44) begin
      n_fail++;
      $display("FAIL flush_next: addr=%h want 00000044", addr);
    end
  endtask

  task automatic test_flush_full;
    stall  = 1'b1;
    ack_en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req !== 1'b0 || valid !== 1'b1 || inst !== 32'hA000_0040) begin
      n_fail++;
      $display("FAIL full_enter: req=%b v=%b inst=%h want 0 1 a0000040",
               req, valid, inst);
    end
    flush  = 1'b1;
    target = 32'h80;
    @(negedge clk);
    flush = 1'b0;
    stall = 1'b0;
    n_checks++;
    if (req !== 1'b1 || addr !== 32'h80 || valid !== 1'b0 ||
        inst !== 32'h0) begin
      n_fail++;
      $display("FAIL full_flush: req=%b addr=%h v=%b inst=%h want 1 80 0 0",
               req, addr, valid, inst);
    end
    push(32'h80);
    @(negedge clk);
    ack_en = 1'b0;
    n_checks++;
    if (addr !== 32'h84) begin
      n_fail++;
      $display("FAIL full_next: addr=%h want 00000084", addr);
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    n_checks++;
    if (req !== 1'b1 || addr !== 32'h84 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_pre: req=%b addr=%h v=%b want 1 84 0", req, addr, valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (req !== 1'b0 || addr !== 32'h0 || valid !== 1'b0 ||
        inst !== 32'h0 || pc4 !== 32'h0) begin
      n_fail++;
      $display("FAIL ar_now: req=%b addr=%h v=%b inst=%h pc4=%h want 0s",
               req, addr, valid, inst, pc4);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_wrap;
    start  = 1'b1;
    flush  = 1'b1;
    target = 32'hFFFF_FFFC;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (req !== 1'b1 || addr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_idle_flush: req=%b addr=%h want 1 fffffffc", req, addr);
    end
    ack_en = 1'b1;
    push(32'hFFFF_FFFC);
    @(negedge clk);
    ack_en = 1'b0;
    n_checks++;
    if (addr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_addr: addr=%h want 00000000", addr);
    end
    @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d entries pending, want 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_ack();
    test_stall();
    test_flush_outstanding();
    test_flush_full();
    test_async_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
